// File: rtl/lock_display_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment driver for the lock unit.
// Inputs are snapshotted once per frame; lockout blinks the panel, unlock lights the last dp.
module lock_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] disp_1,
  input  logic [2:0] disp_2,
  input  logic [2:0] disp_3,
  input  logic [2:0] disp_N,
  input  logic       lock,
  input  logic       unlock,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    SEG_DASH   = 7'b0111111;
  localparam logic [6:0]    SEG_OFF    = 7'b1111111;

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_t;

  slot_t         r_slot;
  slot_t         w_slot_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_cnt_wrap;
  logic          w_frame_end;
  logic [1:0]    w_idx;

  logic [2:0]    w_disp_in [4];
  logic [2:0]    r_sh_digit [4];
  logic          r_sh_lock;
  logic          r_sh_unlock;

  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;

  logic [6:0]    w_seg_code [4];
  logic [3:0]    w_anode_sel;
  logic          w_blank;
  logic [3:0]    w_an_next;
  logic [6:0]    w_seg_next;
  logic          w_dp_next;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  function automatic logic [6:0] numeral(input logic [2:0] v);
    logic [6:0] code;
    case (v)
      3'd0:    code = 7'b1000000;
      3'd1:    code = 7'b1111001;
      3'd2:    code = 7'b0100100;
      3'd3:    code = 7'b0110000;
      3'd4:    code = 7'b0011001;
      3'd5:    code = 7'b0010010;
      3'd6:    code = 7'b0000010;
      default: code = 7'b1111000;
    endcase
    return code;
  endfunction

  assign w_cnt_wrap  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_cnt_wrap && (r_slot == SLOT3);
  assign w_idx       = r_slot;

  assign w_disp_in[0] = disp_1;
  assign w_disp_in[1] = disp_2;
  assign w_disp_in[2] = disp_3;
  assign w_disp_in[3] = disp_N;

  // Slot sequencer: the digit index only moves when the slot counter wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot <= SLOT0;
      r_cnt  <= '0;
    end else begin
      r_slot <= w_slot_next;
      r_cnt  <= w_cnt_next;
    end
  end

  always_comb begin
    w_slot_next = r_slot;
    w_cnt_next  = r_cnt + CW'(1);
    if (w_cnt_wrap) begin
      w_cnt_next = '0;
      case (r_slot)
        SLOT0:   w_slot_next = SLOT1;
        SLOT1:   w_slot_next = SLOT2;
        SLOT2:   w_slot_next = SLOT3;
        default: w_slot_next = SLOT0;
      endcase
    end
  end

  // Shadows change only at the frame boundary so a frame never mixes old and new inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_sh_digit[i] <= '0;
      r_sh_lock   <= 1'b0;
      r_sh_unlock <= 1'b0;
    end else if (w_frame_end) begin
      for (int i = 0; i < 4; i++) r_sh_digit[i] <= w_disp_in[i];
      r_sh_lock   <= lock;
      r_sh_unlock <= unlock;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (!r_sh_lock) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + BW'(1);
    end
  end

  // Entered-digit slots show a dash for "not entered"; the attempts slot always shows a numeral.
  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    if (gi == 3) begin : g_count
      assign w_seg_code[gi] = numeral(r_sh_digit[gi]);
    end else begin : g_entry
      assign w_seg_code[gi] = (r_sh_digit[gi] == 3'd0) ? SEG_DASH : numeral(r_sh_digit[gi]);
    end
    assign w_anode_sel[gi] = (w_idx != 2'(gi));
  end

  assign w_blank = (r_cnt == '0) || (r_sh_lock && r_blink_phase);

  always_comb begin
    w_an_next  = 4'b1111;
    w_seg_next = SEG_OFF;
    w_dp_next  = 1'b1;
    if (!w_blank) begin
      w_an_next  = w_anode_sel;
      w_seg_next = w_seg_code[w_idx];
      w_dp_next  = !(r_sh_unlock && !r_sh_lock && (r_slot == SLOT3));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
      r_dp  <= w_dp_next;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule
